// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Byte FIFO that sits between the character sequencer and the uart_tx
//   serializer. Upstream pushes bytes with wr_valid/wr_ready; downstream the
//   block issues one registered tx_send pulse per byte. It waits for the
//   serializer to go busy and then idle again. It then inserts GAP_CYCLES
//   idle clocks before offering the next byte.
//
//   Optional build macro: UART_TX_FIFO_STATUS_EN
//     Adds the level / overflow / ovf_clr status ports.
//     When the macro is undefined, bytes pushed while the FIFO is full are dropped silently.
`timescale 1ns/1ps

module uart_tx_fifo #(
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter int GAP_CYCLES = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic              tx_ready,
    output logic              tx_send,
    output logic [7:0]        tx_data,
    output logic              empty,
    output logic              full
`ifdef UART_TX_FIFO_STATUS_EN
    ,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    input  logic              ovf_clr
`endif
);

    // Gap counter must hold GAP_CYCLES; keep at least one bit when the gap is 0 or 1.
    localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

    localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP_CYCLES);
    localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1);
    localparam logic [GAP_W-1:0]  GAP_ZERO = GAP_W'(0);
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   CNT_ZERO = (ADDR_W + 1)'(0);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PTR_ZERO = ADDR_W'(0);

    // Sender FSM states
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;
    localparam logic [1:0] ST_GAP       = 2'd3;

    logic [7:0]        mem_r [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [ADDR_W:0]   count_r;
    logic [ADDR_W:0]   count_nxt_s;
    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [GAP_W-1:0]  gap_cnt_r;
    logic [GAP_W-1:0]  gap_nxt_s;
    logic              tx_send_r;
    logic [7:0]        tx_data_r;
    logic              full_s;
    logic              empty_s;
    logic              push_s;
    logic              pop_s;

    assign full_s   = (count_r == CNT_FULL);
    assign empty_s  = (count_r == CNT_ZERO);
    assign wr_ready = ~full_s;
    assign full     = full_s;
    assign empty    = empty_s;
    assign tx_send  = tx_send_r;
    assign tx_data  = tx_data_r;

    // A push is taken only when there is room, even if a pop frees a slot on the same edge.
    assign push_s = wr_valid & ~full_s;
    // Bytes leave only from IDLE, so each send is separated by a full busy/idle/gap cycle.
    assign pop_s  = (state_r == ST_IDLE) & ~empty_s & tx_ready;

    // Storage array: written on accepted pushes, not reset (contents are don't-care when empty).
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Occupancy: push and pop on the same edge cancel out.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Sender FSM next-state and gap counter.
    always_comb begin
        state_nxt_s = state_r;
        gap_nxt_s   = gap_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (pop_s) begin
                    state_nxt_s = ST_WAIT_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT_BUSY: begin
                // Serializer dropping ready means it has taken the byte.
                if (!tx_ready) begin
                    state_nxt_s = ST_WAIT_DONE;
                end else begin
                    state_nxt_s = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_ready) begin
                    if (GAP_CYCLES == 0) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_GAP;
                        gap_nxt_s   = GAP_LOAD;
                    end
                end else begin
                    state_nxt_s = ST_WAIT_DONE;
                end
            end
            ST_GAP: begin
                // The edge that sees gap_cnt==1 is the last gap clock.
                if (gap_cnt_r <= GAP_ONE) begin
                    state_nxt_s = ST_IDLE;
                    gap_nxt_s   = GAP_ZERO;
                end else begin
                    state_nxt_s = ST_GAP;
                    gap_nxt_s   = gap_cnt_r - GAP_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                gap_nxt_s   = GAP_ZERO;
            end
        endcase
    end

    // Pointers, count, FSM and the registered serializer outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r  <= PTR_ZERO;
            rd_ptr_r  <= PTR_ZERO;
            count_r   <= CNT_ZERO;
            state_r   <= ST_IDLE;
            gap_cnt_r <= GAP_ZERO;
            tx_send_r <= 1'b0;
            tx_data_r <= 8'h00;
        end else begin
            count_r   <= count_nxt_s;
            state_r   <= state_nxt_s;
            gap_cnt_r <= gap_nxt_s;
            tx_send_r <= pop_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r  <= rd_ptr_r + PTR_ONE;
                tx_data_r <= mem_r[rd_ptr_r];
            end else begin
                rd_ptr_r  <= rd_ptr_r;
                tx_data_r <= tx_data_r;
            end
        end
    end

`ifdef UART_TX_FIFO_STATUS_EN
    logic overflow_r;

    assign level    = count_r;
    assign overflow = overflow_r;

    // Sticky overflow flag; a new overflow on the clearing edge keeps it set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_r <= 1'b0;
        end else if (wr_valid && full_s) begin
            overflow_r <= 1'b1;
        end else if (ovf_clr) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
//   Directed bench for uart_tx_fifo (DEPTH=16, GAP_CYCLES=10). A small
//   serializer model lowers tx_ready when it sees tx_send. It holds tx_ready
//   low for busy_len clocks and then raises it again. Status ports are
//   exercised when UART_TX_FIFO_STATUS_EN is defined.
`timescale 1ns/1ps

module tb_uart_tx_fifo;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int GAP    = 10;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic       tx_ready;
    logic       tx_send;
    logic [7:0] tx_data;
    logic       empty;
    logic       full;
`ifdef UART_TX_FIFO_STATUS_EN
    logic [ADDR_W:0] level;
    logic            overflow;
    logic            ovf_clr;
`endif

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         pulse_cnt = 0;
    logic [7:0] pulse_data [64];
    int         pulse_cyc  [64];
    logic       prev_send = 1'b0;
    bit         ser_en = 1'b0;
    int         busy_len = 100;
    int         busy = 0;

    uart_tx_fifo #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .tx_ready (tx_ready),
        .tx_send  (tx_send),
        .tx_data  (tx_data),
        .empty    (empty),
        .full     (full)
`ifdef UART_TX_FIFO_STATUS_EN
        ,
        .level    (level),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
`endif
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample just after the edge, log pulses, run the serializer model.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (tx_send === 1'b1) begin
            check("single_cycle_pulse", {31'd0, prev_send}, 32'd0);
            if (pulse_cnt < 64) begin
                pulse_data[pulse_cnt] = tx_data;
                pulse_cyc[pulse_cnt]  = cyc;
            end
            pulse_cnt++;
        end
        prev_send = tx_send;
        if (ser_en) begin
            if (tx_send === 1'b1) begin
                tx_ready = 1'b0;
                busy     = busy_len;
            end else if (busy > 0) begin
                busy--;
                if (busy == 0) tx_ready = 1'b1;
            end
        end
    endtask

    task automatic push(input logic [7:0] d);
        wr_data  = d;
        wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        wr_valid = 1'b0;
        ser_en   = 1'b0;
        busy     = 0;
`ifdef UART_TX_FIFO_STATUS_EN
        ovf_clr  = 1'b0;
`endif
        #12;
        reset_n   = 1'b1;
        pulse_cnt = 0;
        prev_send = 1'b0;
        step();
    endtask

    initial begin
        logic [7:0] hello [6];
        int idx;
        bit acc;
        hello = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0A};

        // ---------------- reset state ----------------
        reset_n  = 1'b0;
        tx_ready = 1'b1;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
`ifdef UART_TX_FIFO_STATUS_EN
        ovf_clr  = 1'b0;
`endif
        #12;
        check("rst_tx_send", {31'd0, tx_send}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'h00);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
`ifdef UART_TX_FIFO_STATUS_EN
        check("rst_level", {27'd0, level}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
`endif
        reset_n = 1'b1;
        step();

        // ---------------- single byte, one-cycle latency ----------------
        push(8'h68);
        check("t1_no_send_yet", {31'd0, tx_send}, 32'd0);
        check("t1_not_empty", {31'd0, empty}, 32'd0);
        step();
        check("t1_send", {31'd0, tx_send}, 32'd1);
        check("t1_data", {24'd0, tx_data}, 32'h68);
        check("t1_empty_after", {31'd0, empty}, 32'd1);
        step();
        check("t1_send_drop", {31'd0, tx_send}, 32'd0);
        check("t1_data_held", {24'd0, tx_data}, 32'h68);

        // ---------------- tx_ready never drops: stuck in WAIT_BUSY ----------------
        push(8'h41);
        repeat (20) step();
        check("t6_one_pulse_only", pulse_cnt, 32'd1);
        check("t6_byte_kept", {31'd0, empty}, 32'd0);

        // ---------------- "hello\n" with 100-clock serializer ----------------
        // Ready is lowered right after a pulse and raised after 100 steps, first
        // sampled high one edge later; GAP+1 edges after that the next pulse
        // appears: pulse-to-pulse interval = 100 + 1 + 11 = 112 clocks.
        do_reset();
        tx_ready = 1'b1;
        busy_len = 100;
        ser_en   = 1'b1;
        for (int i = 0; i < 6; i++) push(hello[i]);
        for (int n = 0; n < 2000 && pulse_cnt < 6; n++) step();
        check("t2_pulse_count", pulse_cnt, 32'd6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t2_data%0d", i), {24'd0, pulse_data[i]}, {24'd0, hello[i]});
            if (i > 0) check($sformatf("t2_interval%0d", i), pulse_cyc[i] - pulse_cyc[i-1], 32'd112);
        end
        check("t2_empty_end", {31'd0, empty}, 32'd1);

        // ---------------- fill to full, 17th dropped ----------------
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 15; i++) push(8'h10 + 8'(i));
        check("t3_not_full_15", {31'd0, full}, 32'd0);
        push(8'h1F);
        check("t3_full", {31'd0, full}, 32'd1);
        check("t3_wr_ready", {31'd0, wr_ready}, 32'd0);
        check("t3_not_empty", {31'd0, empty}, 32'd0);
        push(8'hEE);
        check("t3_still_full", {31'd0, full}, 32'd1);
`ifdef UART_TX_FIFO_STATUS_EN
        check("t3_overflow", {31'd0, overflow}, 32'd1);
        check("t3_level", {27'd0, level}, 32'd16);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("t3_ovf_cleared", {31'd0, overflow}, 32'd0);
`endif
        busy_len = 3;
        tx_ready = 1'b1;
        ser_en   = 1'b1;
        for (int n = 0; n < 600 && pulse_cnt < 16; n++) step();
        repeat (40) step();
        check("t3_drain_count", pulse_cnt, 32'd16);
        for (int i = 0; i < 16; i++)
            check($sformatf("t3_data%0d", i), {24'd0, pulse_data[i]}, 32'h10 + i);
        check("t3_empty_end", {31'd0, empty}, 32'd1);

        // ---------------- push+pop at count 5, then wraparound over 40 bytes ----------------
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
        tx_ready = 1'b1;
        wr_data  = 8'hA5;
        wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
        tx_ready = 1'b0;
        check("t4_pop_send", {31'd0, tx_send}, 32'd1);
        check("t4_pop_data", {24'd0, tx_data}, 32'hA0);
`ifdef UART_TX_FIFO_STATUS_EN
        check("t4_level5", {27'd0, level}, 32'd5);
`endif
        // 5 held + 11 more must reach exactly 16.
        for (int i = 6; i < 16; i++) push(8'hA0 + 8'(i));
        check("t4_not_full_at_15", {31'd0, full}, 32'd0);
        push(8'hB0);
        check("t4_full_at_16", {31'd0, full}, 32'd1);
        idx      = 17;
        busy_len = 3;
        tx_ready = 1'b1;
        ser_en   = 1'b1;
        for (int n = 0; n < 3000 && pulse_cnt < 40; n++) begin
            wr_valid = (idx < 40);
            wr_data  = 8'hA0 + 8'(idx);
            acc      = wr_valid && wr_ready;
            step();
            if (acc) idx++;
        end
        wr_valid = 1'b0;
        check("t4_total_pulses", pulse_cnt, 32'd40);
        for (int i = 0; i < 40; i++)
            check($sformatf("t4_order%0d", i), {24'd0, pulse_data[i]}, {24'd0, 8'hA0 + 8'(i)});

        // ---------------- reset with 3 bytes queued, FSM in WAIT_DONE ----------------
        do_reset();
        tx_ready = 1'b1;
        busy_len = 50;
        ser_en   = 1'b1;
        for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
        for (int n = 0; n < 20 && pulse_cnt < 1; n++) step();
        repeat (5) step();
        check("t5_one_sent", pulse_cnt, 32'd1);
        check("t5_queued", {31'd0, empty}, 32'd0);
        reset_n = 1'b0;
        #1;
        check("t5_rst_send", {31'd0, tx_send}, 32'd0);
        check("t5_rst_empty", {31'd0, empty}, 32'd1);
        check("t5_rst_full", {31'd0, full}, 32'd0);
        check("t5_rst_data", {24'd0, tx_data}, 32'h00);
        #10;
        ser_en    = 1'b0;
        busy      = 0;
        tx_ready  = 1'b1;
        reset_n   = 1'b1;
        pulse_cnt = 0;
        repeat (30) step();
        check("t5_no_send_after", pulse_cnt, 32'd0);
        check("t5_empty_after", {31'd0, empty}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
